// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter in front of a shared UART TX core
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int BUSY_WAIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_byte_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic                 uart_tx_busy_i,
    output logic                 uart_tx_start_o,
    output logic [7:0]           uart_tx_byte_o,
    output logic [2:0]           owner_o,
    output logic                 locked_o
);

    localparam int CW = $clog2(BUSY_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic [NUM_REQ-1:0]   ready_q;
    logic                 start_q;
    logic [7:0]           byte_q;
    logic [2:0]           owner_q;
    logic                 locked_q;
    logic                 last_q;
    logic [CW-1:0]        cnt_q;

    logic                 grant_vld_d;
    logic [2:0]           grant_idx_d;
    logic [NUM_REQ-1:0]   grant_oh_d;
    logic [7:0]           grant_byte_d;
    logic                 grant_last_d;

    // Pick the next requester: scan owner+1 .. owner+NUM_REQ, the owner itself
    // coming last; while a packet is open only the owner (k == NUM_REQ) may win.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_idx_d = owner_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid_i[i] && ((int'(owner_q) + k) % NUM_REQ == i)
                    && (!locked_q || k == NUM_REQ)) begin
                    grant_vld_d = 1'b1;
                    grant_idx_d = 3'(i);
                end
            end
        end
    end

    // Route the winner's byte/last and build its one-hot ready.
    always_comb begin
        grant_oh_d   = '0;
        grant_byte_d = '0;
        grant_last_d = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_d == 3'(i)) begin
                grant_oh_d[i] = 1'b1;
                grant_byte_d  = req_byte_i[8*i +: 8];
                grant_last_d  = req_last_i[i];
            end
        end
    end

    // Transmit sequencer: accept, launch when the core is free, wait for busy
    // to rise (bounded), then wait for it to fall before the next accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ready_q  <= '0;
            start_q  <= 1'b0;
            byte_q   <= '0;
            owner_q  <= 3'(NUM_REQ - 1);
            locked_q <= 1'b0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ready_q <= '0;
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        ready_q <= grant_oh_d;
                        byte_q  <= grant_byte_d;
                        owner_q <= grant_idx_d;
                        last_q  <= grant_last_d;
                        state_q <= START;
                    end
                end
                START: begin
                    if (!uart_tx_busy_i) begin
                        start_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (uart_tx_busy_i || cnt_q == CNT_MAX) begin
                        state_q <= WAIT_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_tx_busy_i) begin
                        locked_q <= ~last_q;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o     = ready_q;
    assign uart_tx_start_o = start_q;
    assign uart_tx_byte_o  = byte_q;
    assign owner_o         = owner_q;
    assign locked_o        = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [23:0] req_byte = '0;
    logic [2:0]  req_last = '0;
    logic [2:0]  req_ready;
    logic        busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic [2:0]  owner;
    logic        locked;

    uart_tx_arbiter #(.NUM_REQ(3), .BUSY_WAIT(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_byte_i     (req_byte),
        .req_last_i     (req_last),
        .req_ready_o    (req_ready),
        .uart_tx_busy_i (busy),
        .uart_tx_start_o(tx_start),
        .uart_tx_byte_o (tx_byte),
        .owner_o        (owner),
        .locked_o       (locked)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int valid_cyc = 0;
    int ready_cyc = 0;
    int start_cyc = 0;
    int start_cnt = 0;
    int bm_delay = 1;
    int bm_len = 3;
    bit bm_en = 1'b1;
    bit en [3] = '{1'b1, 1'b1, 1'b1};
    int dcnt = 0;
    int bcnt = 0;

    logic [8:0] txq [3][$];
    logic [7:0] exp_q [$];
    int         grant_log [$];
    int         start_log [$];

    typedef struct {
        int         req;
        logic [7:0] data;
        bit         last;
        int         exp_owner;
        int         exp_locked;
    } vec_t;

    vec_t vt [6];
    int   t3_exp [6] = '{0, 1, 2, 0, 1, 2};

    function automatic void chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: present the head of each queue, retire it on req_ready.
    always @(negedge clk) begin
        if (!rst_n) begin
            req_valid = '0;
            req_last  = '0;
            req_byte  = '0;
            for (int i = 0; i < 3; i++) txq[i].delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    void'(txq[i].pop_front());
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && txq[i].size() != 0 && en[i]) begin
                    req_valid[i]         = 1'b1;
                    req_byte[8*i +: 8]   = txq[i][0][7:0];
                    req_last[i]          = txq[i][0][8];
                    valid_cyc            = cyc;
                end
            end
        end
    end

    // UART core model: busy rises bm_delay cycles after a start, stays bm_len cycles.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            busy = 1'b0;
            dcnt = 0;
            bcnt = 0;
        end else begin
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    busy = 1'b1;
                    bcnt = bm_len;
                end
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) busy = 1'b0;
            end
            if (tx_start && bm_en) dcnt = bm_delay;
        end
    end

    // Output monitor and scoreboard.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n) begin
            if (req_ready != 3'b000) begin
                chk("ready_onehot", $countones(req_ready), 1);
                for (int i = 0; i < 3; i++) if (req_ready[i]) grant_log.push_back(i);
                ready_cyc = cyc;
            end
            if (tx_start) begin
                start_cnt++;
                start_log.push_back(cyc);
                start_cyc = cyc;
                chk("start_while_busy", int'(busy), 0);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_start: got byte %02h expected none", tx_byte);
                end else begin
                    e = exp_q.pop_front();
                    chk("uart_byte", int'(tx_byte), int'(e));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_sb(input int budget, input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g0;
        int s0;
        int n;

        vt[0] = '{0, 8'h00, 1'b1, 0, 0};
        vt[1] = '{2, 8'hA5, 1'b1, 2, 0};
        vt[2] = '{1, 8'h3C, 1'b0, 1, 1};
        vt[3] = '{1, 8'hC3, 1'b1, 1, 0};
        vt[4] = '{0, 8'h7E, 1'b0, 0, 1};
        vt[5] = '{0, 8'h81, 1'b1, 0, 0};

        step(3);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_start", int'(tx_start), 0);
        chk("rst_byte", int'(tx_byte), 0);
        chk("rst_owner", int'(owner), 2);
        chk("rst_locked", int'(locked), 0);
        @(negedge clk) rst_n = 1'b1;

        // Table of single-requester transfers from an idle channel.
        for (int v = 0; v < 6; v++) begin
            g0 = grant_log.size();
            exp_q.push_back(vt[v].data);
            txq[vt[v].req].push_back({vt[v].last, vt[v].data});
            wait_sb(60, "vec_sb");
            step(20);
            chk("vec_grant_cnt", grant_log.size(), g0 + 1);
            if (grant_log.size() > g0) chk("vec_grant_idx", grant_log[g0], vt[v].req);
            chk("vec_owner", int'(owner), vt[v].exp_owner);
            chk("vec_locked", int'(locked), vt[v].exp_locked);
            chk("vec_accept_lat", ready_cyc - valid_cyc, 1);
            chk("vec_start_lat", start_cyc - ready_cyc, 1);
        end

        // T2: req0 arrives mid-packet of req1 and must wait for the last byte.
        g0 = grant_log.size();
        en[0] = 1'b0;
        txq[0].push_back({1'b1, 8'hFF});
        txq[1].push_back({1'b0, 8'h11});
        txq[1].push_back({1'b0, 8'h22});
        txq[1].push_back({1'b0, 8'h33});
        txq[1].push_back({1'b1, 8'h44});
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'hFF);
        n = 0;
        while (exp_q.size() > 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("t2_locked_mid", int'(locked), 1);
        chk("t2_owner_mid", int'(owner), 1);
        en[0] = 1'b1;
        wait_sb(200, "t2_sb");
        step(20);
        chk("t2_grant_cnt", grant_log.size(), g0 + 5);
        for (int k = 0; k < 5; k++)
            if (grant_log.size() > g0 + k) chk("t2_grant_order", grant_log[g0 + k], (k < 4) ? 1 : 0);
        chk("t2_locked_end", int'(locked), 0);

        // T3: all requesters stream one-byte packets from reset.
        do_reset();
        g0 = grant_log.size();
        for (int i = 0; i < 3; i++) begin
            txq[i].push_back({1'b1, 8'(8'hA0 + 8'(16 * i))});
            txq[i].push_back({1'b1, 8'(8'hA1 + 8'(16 * i))});
        end
        for (int k = 0; k < 6; k++) exp_q.push_back(8'(8'hA0 + 8'(16 * (k % 3)) + 8'(k / 3)));
        wait_sb(300, "t3_sb");
        step(20);
        chk("t3_grant_cnt", grant_log.size(), g0 + 6);
        for (int k = 0; k < 6; k++)
            if (grant_log.size() > g0 + k) chk("t3_grant_order", grant_log[g0 + k], t3_exp[k]);

        // T4: slow busy rise and long busy pulse.
        bm_delay = 2;
        bm_len = 10;
        s0 = start_cnt;
        txq[2].push_back({1'b0, 8'hD1});
        txq[2].push_back({1'b0, 8'hD2});
        txq[2].push_back({1'b1, 8'hD3});
        exp_q.push_back(8'hD1);
        exp_q.push_back(8'hD2);
        exp_q.push_back(8'hD3);
        wait_sb(300, "t4_sb");
        step(30);
        chk("t4_start_cnt", start_cnt - s0, 3);
        chk("t4_locked_end", int'(locked), 0);
        bm_delay = 1;
        bm_len = 3;

        // T5: busy never rises; each byte times out after BUSY_WAIT cycles.
        bm_en = 1'b0;
        s0 = start_log.size();
        txq[0].push_back({1'b0, 8'hE1});
        txq[0].push_back({1'b0, 8'hE2});
        txq[0].push_back({1'b1, 8'hE3});
        exp_q.push_back(8'hE1);
        exp_q.push_back(8'hE2);
        exp_q.push_back(8'hE3);
        wait_sb(200, "t5_sb");
        step(20);
        chk("t5_start_cnt", start_log.size(), s0 + 3);
        if (start_log.size() >= s0 + 3) begin
            chk("t5_period_1", start_log[s0 + 1] - start_log[s0], 7);
            chk("t5_period_2", start_log[s0 + 2] - start_log[s0 + 1], 7);
        end
        bm_en = 1'b1;

        // T6: reset in the middle of a 3-byte packet.
        txq[2].push_back({1'b0, 8'h61});
        txq[2].push_back({1'b0, 8'h62});
        txq[2].push_back({1'b1, 8'h63});
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h62);
        wait_sb(200, "t6_sb");
        #1;
        chk("t6_locked_pre", int'(locked), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", int'(req_ready), 0);
        chk("t6_rst_start", int'(tx_start), 0);
        chk("t6_rst_byte", int'(tx_byte), 0);
        chk("t6_rst_locked", int'(locked), 0);
        chk("t6_rst_owner", int'(owner), 2);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        s0 = start_cnt;
        step(12);
        chk("t6_no_start_after_release", start_cnt - s0, 0);
        g0 = grant_log.size();
        txq[0].push_back({1'b1, 8'h70});
        txq[2].push_back({1'b1, 8'h71});
        exp_q.push_back(8'h70);
        exp_q.push_back(8'h71);
        wait_sb(200, "t6_sb_post");
        step(20);
        chk("t6_grant_cnt", grant_log.size(), g0 + 2);
        if (grant_log.size() >= g0 + 2) begin
            chk("t6_first_grant", grant_log[g0], 0);
            chk("t6_second_grant", grant_log[g0 + 1], 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
